// File: rtl/pc_gen_if.sv
// Pipeline-side bundle for the fetch-PC generator: redirect requests in,
// fetch PC, RAS prediction and flush controls out.
interface pc_gen_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 16
);
    logic              stall;
    logic              id_br_taken;
    logic [ADDR_W-1:0] id_br_target;
    logic              id_call;
    logic [ADDR_W-1:0] id_link;
    logic              id_ret;
    logic              ex_mispredict;
    logic [ADDR_W-1:0] ex_target;
    logic              mem_ex;
    logic              mem_eret;
    logic [ADDR_W-1:0] epc;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] npc;
    logic [ADDR_W-1:0] ras_pred;
    logic              ras_hit;
    logic              if_flush;
    logic              id_flush;
    logic              ex_flush;
    logic              mem_flush;
    logic              pc_redirect;
    logic              ras_empty;
    logic              ras_full;
    logic [CNT_W-1:0]  mispredict_cnt;

    modport slave (
        input  stall, id_br_taken, id_br_target, id_call, id_link, id_ret,
               ex_mispredict, ex_target, mem_ex, mem_eret, epc,
        output pc, npc, ras_pred, ras_hit, if_flush, id_flush, ex_flush,
               mem_flush, pc_redirect, ras_empty, ras_full, mispredict_cnt
    );

    modport master (
        output stall, id_br_taken, id_br_target, id_call, id_link, id_ret,
               ex_mispredict, ex_target, mem_ex, mem_eret, epc,
        input  pc, npc, ras_pred, ras_hit, if_flush, id_flush, ex_flush,
               mem_flush, pc_redirect, ras_empty, ras_full, mispredict_cnt
    );
endinterface

// File: rtl/pc_gen.sv
// Registered fetch-PC generator with prioritised redirects, circular
// return-address stack, stage flushes and a saturating mispredict counter.
module pc_gen #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = 32'hBFC0_0000,
    parameter logic [ADDR_W-1:0] EX_VECTOR = 32'hBFC0_0380,
    parameter int unsigned       ERET_OFS  = 4,
    parameter int unsigned       RAS_DEPTH = 4,
    parameter int unsigned       CNT_W     = 16
) (
    input  logic      clk,
    input  logic      resetn,
    pc_gen_if.slave   pcif
);
    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [PTR_W:0] RAS_FULL_CNT = (PTR_W+1)'(RAS_DEPTH);

    typedef enum logic [2:0] {
        SEL_EXC,
        SEL_ERET,
        SEL_MISP,
        SEL_RAS,
        SEL_BR,
        SEL_SEQ
    } npc_sel_e;

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_ras [RAS_DEPTH];
    logic [PTR_W-1:0]  r_ptr;
    logic [PTR_W:0]    r_rcnt;
    logic [CNT_W-1:0]  r_mcnt;

    npc_sel_e          w_sel;
    logic [ADDR_W-1:0] w_npc;
    logic [ADDR_W-1:0] w_pc_seq;
    logic [ADDR_W-1:0] w_ras_top;
    logic [PTR_W-1:0]  w_ptr_top;
    logic [PTR_W-1:0]  w_ras_waddr;
    logic              w_ras_empty;
    logic              w_ras_full;
    logic              w_ras_ok;
    logic              w_ras_we;
    logic              w_pop_hit;
    logic              w_hard_redir;
    logic              w_pc_en;

    always_comb begin
        w_pc_seq     = r_pc + ADDR_W'(4);
        w_ptr_top    = r_ptr - PTR_W'(1);
        w_ras_top    = r_ras[w_ptr_top];
        w_ras_empty  = (r_rcnt == '0);
        w_ras_full   = (r_rcnt == RAS_FULL_CNT);
        w_pop_hit    = pcif.id_ret && !w_ras_empty;
        w_hard_redir = pcif.mem_ex || pcif.mem_eret || pcif.ex_mispredict;
        w_pc_en      = !pcif.stall || w_hard_redir;
        w_ras_ok     = !pcif.stall && !w_hard_redir;
        w_ras_we     = w_ras_ok && pcif.id_call;
        // call+ret in one cycle replaces the top entry instead of pushing
        w_ras_waddr  = w_pop_hit ? w_ptr_top : r_ptr;

        w_sel = SEL_SEQ;
        if (pcif.mem_ex)             w_sel = SEL_EXC;
        else if (pcif.mem_eret)      w_sel = SEL_ERET;
        else if (pcif.ex_mispredict) w_sel = SEL_MISP;
        else if (w_pop_hit)          w_sel = SEL_RAS;
        else if (pcif.id_br_taken)   w_sel = SEL_BR;

        case (w_sel)
            SEL_EXC:  w_npc = EX_VECTOR;
            SEL_ERET: w_npc = pcif.epc + ADDR_W'(ERET_OFS);
            SEL_MISP: w_npc = pcif.ex_target;
            SEL_RAS:  w_npc = w_ras_top;
            SEL_BR:   w_npc = pcif.id_br_target;
            default:  w_npc = w_pc_seq;
        endcase
    end

    always_comb begin
        pcif.pc             = r_pc;
        pcif.npc            = w_npc;
        pcif.ras_pred       = w_ras_top;
        pcif.ras_hit        = (w_sel == SEL_RAS);
        pcif.pc_redirect    = (w_sel != SEL_SEQ);
        pcif.if_flush       = w_hard_redir;
        pcif.id_flush       = w_hard_redir;
        pcif.ex_flush       = pcif.mem_ex || pcif.mem_eret;
        pcif.mem_flush      = pcif.mem_ex || pcif.mem_eret;
        pcif.ras_empty      = w_ras_empty;
        pcif.ras_full       = w_ras_full;
        pcif.mispredict_cnt = r_mcnt;
    end

    always_ff @(posedge clk) begin
        if (w_ras_we) begin
            r_ras[w_ras_waddr] <= pcif.id_link;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_pc   <= RESET_PC;
            r_ptr  <= '0;
            r_rcnt <= '0;
            r_mcnt <= '0;
        end else begin
            if (w_pc_en) begin
                r_pc <= w_npc;
            end
            if (pcif.ex_mispredict && (r_mcnt != '1)) begin
                r_mcnt <= r_mcnt + CNT_W'(1);
            end
            if (pcif.mem_ex || pcif.mem_eret) begin
                r_rcnt <= '0;
            end else if (w_ras_ok) begin
                if (pcif.id_call && !w_pop_hit) begin
                    r_ptr <= r_ptr + PTR_W'(1);
                    if (!w_ras_full) begin
                        r_rcnt <= r_rcnt + (PTR_W+1)'(1);
                    end
                end else if (w_pop_hit && !pcif.id_call) begin
                    r_ptr  <= w_ptr_top;
                    r_rcnt <= r_rcnt - (PTR_W+1)'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: reset, stall/branch, RAS push/pop/wrap,
// combined call+ret, exception/eret/mispredict priority and counter saturation.
module tb_pc_gen;
    logic clk;
    logic resetn;
    int   n_checks;
    int   n_fail;
    logic [31:0] exp_pc;

    pc_gen_if #(.ADDR_W(32), .CNT_W(16)) u_if ();

    pc_gen #(
        .ADDR_W    (32),
        .RESET_PC  (32'hBFC0_0000),
        .EX_VECTOR (32'hBFC0_0380),
        .ERET_OFS  (4),
        .RAS_DEPTH (4),
        .CNT_W     (16)
    ) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .pcif   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic clear_inputs();
        u_if.stall         = 1'b0;
        u_if.id_br_taken   = 1'b0;
        u_if.id_br_target  = '0;
        u_if.id_call       = 1'b0;
        u_if.id_link       = '0;
        u_if.id_ret        = 1'b0;
        u_if.ex_mispredict = 1'b0;
        u_if.ex_target     = '0;
        u_if.mem_ex        = 1'b0;
        u_if.mem_eret      = 1'b0;
        u_if.epc           = '0;
    endtask

    // Check npc before the edge, then pc after it against the bench's own PC model.
    task automatic step(input string tag, input logic [31:0] exp_npc, input logic upd);
        #1;
        check_eq({tag, "_npc"}, u_if.npc, exp_npc);
        @(posedge clk);
        #1;
        if (upd) exp_pc = exp_npc;
        check_eq({tag, "_pc"}, u_if.pc, exp_pc);
    endtask

    initial begin
        logic [31:0] links [5];
        logic [31:0] pops  [4];
        links = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h50};
        pops  = '{32'h50, 32'h40, 32'h30, 32'h20};
        n_checks = 0;
        n_fail   = 0;
        clear_inputs();

        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_pc = 32'hBFC0_0000;
        check_eq("rst_pc", u_if.pc, exp_pc);
        check_eq("rst_empty", u_if.ras_empty, 1);
        check_eq("rst_full", u_if.ras_full, 0);
        check_eq("rst_mcnt", u_if.mispredict_cnt, 0);
        check_eq("rst_flush", {u_if.if_flush, u_if.id_flush, u_if.ex_flush, u_if.mem_flush}, 0);
        resetn = 1'b1;

        #1;
        check_eq("free_redir", u_if.pc_redirect, 0);
        step("free1", 32'hBFC0_0004, 1'b1);
        step("free2", 32'hBFC0_0008, 1'b1);

        u_if.stall        = 1'b1;
        u_if.id_br_taken  = 1'b1;
        u_if.id_br_target = 32'h8000_0100;
        #1;
        check_eq("stall_redir", u_if.pc_redirect, 1);
        step("stall_hold", 32'h8000_0100, 1'b0);
        u_if.stall = 1'b0;
        step("stall_rel", 32'h8000_0100, 1'b1);
        clear_inputs();

        u_if.id_call = 1'b1;
        for (int i = 0; i < 5; i++) begin
            u_if.id_link = links[i];
            step("push", exp_pc + 32'd4, 1'b1);
            check_eq("push_full", u_if.ras_full, (i >= 3) ? 1 : 0);
        end
        check_eq("push_pred", u_if.ras_pred, 32'h50);
        u_if.id_call = 1'b0;
        u_if.id_ret  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("pop_hit", u_if.ras_hit, 1);
            step("pop", pops[i], 1'b1);
        end
        check_eq("pop_empty", u_if.ras_empty, 1);
        #1;
        check_eq("pop5_hit", u_if.ras_hit, 0);
        check_eq("pop5_redir", u_if.pc_redirect, 0);
        step("pop5", 32'h24, 1'b1);
        u_if.id_ret = 1'b0;

        u_if.id_call = 1'b1;
        u_if.id_link = 32'h100;
        step("push100", 32'h28, 1'b1);
        u_if.id_link = 32'h200;
        u_if.id_ret  = 1'b1;
        #1;
        check_eq("callret_hit", u_if.ras_hit, 1);
        step("callret", 32'h100, 1'b1);
        check_eq("callret_pred", u_if.ras_pred, 32'h200);
        check_eq("callret_empty", u_if.ras_empty, 0);
        u_if.id_call = 1'b0;
        step("pop200", 32'h200, 1'b1);
        check_eq("pop200_empty", u_if.ras_empty, 1);
        u_if.id_ret  = 1'b0;
        u_if.id_call = 1'b1;
        u_if.id_link = 32'h300;
        step("push300", 32'h204, 1'b1);
        check_eq("push300_empty", u_if.ras_empty, 0);
        clear_inputs();

        u_if.stall         = 1'b1;
        u_if.mem_ex        = 1'b1;
        u_if.mem_eret      = 1'b1;
        u_if.ex_mispredict = 1'b1;
        u_if.ex_target     = 32'h1234;
        u_if.epc           = 32'h8000_0010;
        u_if.id_ret        = 1'b1;
        #1;
        check_eq("all_flush", {u_if.if_flush, u_if.id_flush, u_if.ex_flush, u_if.mem_flush}, 4'hF);
        check_eq("all_hit", u_if.ras_hit, 0);
        step("all", 32'hBFC0_0380, 1'b1);
        check_eq("all_rasclr", u_if.ras_empty, 1);
        check_eq("all_mcnt", u_if.mispredict_cnt, 1);
        clear_inputs();

        u_if.mem_eret = 1'b1;
        u_if.epc      = 32'h8000_0010;
        #1;
        check_eq("eret_flush", {u_if.if_flush, u_if.id_flush, u_if.ex_flush, u_if.mem_flush}, 4'hF);
        step("eret", 32'h8000_0014, 1'b1);
        clear_inputs();

        u_if.ex_mispredict = 1'b1;
        u_if.ex_target     = 32'h1000;
        u_if.id_br_taken   = 1'b1;
        u_if.id_br_target  = 32'h4444;
        #1;
        check_eq("misp_flush", {u_if.if_flush, u_if.id_flush, u_if.ex_flush, u_if.mem_flush}, 4'hC);
        step("misp", 32'h1000, 1'b1);
        check_eq("misp_mcnt", u_if.mispredict_cnt, 2);
        u_if.id_br_taken = 1'b0;

        u_if.ex_target = 32'h2000;
        for (int i = 0; i < 65539; i++) @(posedge clk);
        #1;
        check_eq("sat_mcnt", u_if.mispredict_cnt, 32'hFFFF);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check_eq("midrst_mcnt", u_if.mispredict_cnt, 0);
        check_eq("midrst_pc", u_if.pc, 32'hBFC0_0000);
        resetn = 1'b1;
        clear_inputs();
        exp_pc = 32'hBFC0_0000;
        step("post_rst", 32'hBFC0_0004, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
